pulse_delay_fsm: RTL and testbench
==================================

PULSE_DELAY_FSM -- requirements
Module: pulse_delay_fsm

Interface
REQ-001 Parameter CNT_W, default 8: width of the delay and width counters and of the dly/wid inputs.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on posedge clk only.
REQ-003 Port rst, input, 1: reset, synchronous, active-low; rst==0 sampled at posedge clk SHALL reset the block.
REQ-004 Port trig, input, 1: start request, sampled at posedge clk.
REQ-005 Port clr, input, 1: synchronous cancel of the current operation, active-high.
REQ-006 Port dly, input, CNT_W: delay in cycles from accepted trig to first y cycle, captured on acceptance.
REQ-007 Port wid, input, CNT_W: pulse width in cycles, captured on acceptance.
REQ-008 Port y, output, 1: registered delayed pulse.
REQ-009 Port busy, output, 1: registered; high while an accepted request is in progress.
REQ-010 Port done, output, 1: registered one-cycle completion strobe.
REQ-011 Port miss, output, 1: registered one-cycle strobe flagging a dropped trig.

Function
REQ-012 The block SHALL be an FSM with exactly three states: IDLE, WAIT, PULSE.
REQ-013 trig SHALL be accepted only at an edge where state==IDLE, clr==0 and rst==1; dly and wid SHALL be latched at that edge.
REQ-014 For trig accepted at edge k with latched dly=D: y SHALL first be 1 after edge k+D+1 (D=0: y high after edge k+1, WAIT skipped).
REQ-015 y SHALL stay 1 for exactly W cycles, W=wid, with wid==0 treated as W=1; y SHALL be 0 after edge k+D+1+W.
REQ-016 Transitions: IDLE->WAIT on accept with D>0; IDLE->PULSE on accept with D==0; WAIT->PULSE after D cycles; PULSE->IDLE after W cycles.
REQ-017 busy SHALL be 1 from edge k+1 through the last y cycle, falling at the same edge as y.
REQ-018 done SHALL be 1 for exactly one cycle, asserted at the edge where y falls after normal completion.
REQ-019 trig==1 at an edge where state!=IDLE and clr==0 SHALL be dropped, SHALL NOT restart or extend the operation, and SHALL set miss=1 for the following cycle only.
REQ-020 trig at the same edge that PULSE->IDLE occurs SHALL count as state!=IDLE: dropped, miss asserted; a new trig is accepted from the next edge.
REQ-021 clr==1 at any edge SHALL force IDLE; y, busy SHALL be 0 after that edge; done and miss SHALL NOT assert for that edge.
REQ-022 clr and trig high at the same edge: clr wins; trig dropped; miss SHALL NOT assert.
REQ-023 dly and wid changes while busy SHALL NOT affect the running operation.
REQ-024 Counters SHALL not wrap: maximum D and W are 2^CNT_W-1 and SHALL produce exactly that many cycles.
REQ-025 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-026 rst==0 at posedge clk SHALL set state IDLE and y, busy, done, miss all to 0, and clear the latched dly/wid and counters.
REQ-027 rst SHALL take priority over clr and trig, including mid-WAIT or mid-PULSE; no done or miss SHALL follow a reset.
REQ-028 Outputs SHALL be 0 from the first edge with rst==0 until a trig is accepted after rst returns to 1.

Verification
REQ-029 trig at edge 10, dly=3, wid=2 -> busy=1 after edges 11-15; y=1 after edges 14,15; y=0, busy=0, done=1 after edge 16; done=0 after edge 17.
REQ-030 trig at edge 10, dly=0, wid=0 -> y=1 after edge 11 only; done=1 after edge 12.
REQ-031 trig at edge 10 (dly=5, wid=1), trig again at edges 12 and 16 -> miss=1 after edges 13 and 17 (edge 16 is the PULSE->IDLE edge); y timing unchanged (y=1 after edge 16 only).
REQ-032 trig at edge 10 (dly=4, wid=3), clr at edge 12 -> y, busy=0 after edge 12; no done; trig at edge 13 accepted normally.
REQ-033 rst=0 at edge 15 during PULSE from trig at edge 10 (dly=2, wid=8) -> all outputs 0 after edge 15 and stay 0; no done.
REQ-034 dly=255, wid=255 (CNT_W=8), trig at edge 0 -> y=1 after edges 256 through 510; done after edge 511.

Source files
------------

// File: rtl/pulse_delay_fsm.sv
// Retriggerable-safe delayed pulse generator: an accepted trig produces a pulse of
// wid cycles after dly cycles, with busy/done/miss status strobes, all registered.
module pulse_delay_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             clr,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] wid,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             miss
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    PULSE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic             y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             miss_q, miss_d;
  logic             miss_pend_q, miss_pend_d;

  // Outputs lag the state by one edge; done is the edge after the last y cycle,
  // recognised as "y was high and the FSM is now idle".
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    wid_d       = wid_q;
    y_d         = (state_q == PULSE);
    busy_d      = (state_q == WAIT) || (state_q == PULSE);
    done_d      = y_q && (state_q == IDLE);
    miss_pend_d = trig && (state_q != IDLE);
    miss_d      = miss_pend_q;

    case (state_q)
      IDLE: begin
        if (trig) begin
          wid_d = (wid == '0) ? ONE : wid;
          if (dly == '0) begin
            state_d = PULSE;
            cnt_d   = (wid == '0) ? ONE : wid;
          end else begin
            state_d = WAIT;
            cnt_d   = dly;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= ONE) begin
          state_d = PULSE;
          cnt_d   = wid_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      PULSE: begin
        if (cnt_q <= ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        y_d         = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        miss_pend_d = 1'b0;
        miss_d      = 1'b0;
      end
    endcase

    // Cancel overrides everything, including a trig at the same edge.
    if (clr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      y_d         = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      miss_pend_d = 1'b0;
      miss_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wid_q       <= '0;
      y_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= 1'b0;
      miss_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wid_q       <= wid_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign miss = miss_q;

endmodule

// File: tb/tb_pulse_delay_fsm.sv
// Scenario bench for pulse_delay_fsm: expected {y,busy,done,miss} per edge are queued
// from a timing model, then popped and compared one edge at a time.
module tb_pulse_delay_fsm;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, trig, clr;
  logic [CNT_W-1:0] dly, wid;
  logic             y, busy, done, miss;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;

  always #5 clk = ~clk;

  pulse_delay_fsm #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .trig(trig),
    .clr (clr),
    .dly (dly),
    .wid (wid),
    .y   (y),
    .busy(busy),
    .done(done),
    .miss(miss)
  );

  // Outputs after edge t for one operation accepted at edge 0: {y,busy,done,miss}.
  function automatic logic [3:0] op_exp(int t, int d, int w);
    int         we;
    logic [3:0] e;
    we = (w == 0) ? 1 : w;
    e  = 4'b0000;
    if (t >= d + 1 && t <= d + we) e[3] = 1'b1;
    if (t >= 1 && t <= d + we)     e[2] = 1'b1;
    if (t == d + we + 1)           e[1] = 1'b1;
    return e;
  endfunction

  task automatic drive(input bit r, input bit tr, input bit c, input int d, input int w);
    rst  = r;
    trig = tr;
    clr  = c;
    dly  = CNT_W'(d);
    wid  = CNT_W'(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) sb_q.push_back(4'b0000);
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL reset t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // dly=3 wid=2; inputs changed while busy must not matter.
  task automatic test_basic();
    for (int t = 0; t <= 8; t++) sb_q.push_back(op_exp(t, 3, 2));
    for (int t = 0; t <= 8; t++) begin
      if (t == 0) drive(1'b1, 1'b1, 1'b0, 3, 2);
      else        drive(1'b1, 1'b0, 1'b0, 7, 9);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL basic t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  task automatic test_zero();
    for (int t = 0; t <= 3; t++) sb_q.push_back(op_exp(t, 0, 0));
    for (int t = 0; t <= 3; t++) begin
      drive(1'b1, t == 0, 1'b0, 0, 0);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL zero t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // Drops at 2 (WAIT) and 6 (PULSE->IDLE edge); trig at 7 is accepted (dly=0,wid=1).
  task automatic test_drop();
    for (int t = 0; t <= 10; t++)
      sb_q.push_back(op_exp(t, 5, 1) | op_exp(t - 7, 0, 1) | {3'b000, (t == 3 || t == 7)});
    for (int t = 0; t <= 10; t++) begin
      drive(1'b1, (t == 0 || t == 2 || t == 6 || t == 7), 1'b0, (t == 7) ? 0 : 5, 1);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL drop t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // clr together with trig at 2 cancels without miss; trig at 3 starts normally.
  task automatic test_clr();
    for (int t = 0; t <= 12; t++) begin
      if (t < 2)       sb_q.push_back(op_exp(t, 4, 3));
      else if (t == 2) sb_q.push_back(4'b0000);
      else             sb_q.push_back(op_exp(t - 3, 4, 3));
    end
    for (int t = 0; t <= 12; t++) begin
      drive(1'b1, (t == 0 || t == 2 || t == 3), t == 2, 4, 3);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL clr t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // Reset (with a trig) mid-PULSE, quiet period, then a fresh request at 15.
  task automatic test_rst_mid();
    for (int t = 0; t <= 19; t++) begin
      if (t < 5)       sb_q.push_back(op_exp(t, 2, 8));
      else if (t < 15) sb_q.push_back(4'b0000);
      else             sb_q.push_back(op_exp(t - 15, 1, 1));
    end
    for (int t = 0; t <= 19; t++) begin
      drive(t != 5, (t == 0 || t == 5 || t == 15), 1'b0,
            (t == 15) ? 1 : 2, (t == 15) ? 1 : 8);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL rst_mid t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // Continuous trig with dly=1 wid=1: accepted at 0,3,6, everything else dropped.
  task automatic test_back_to_back();
    for (int t = 0; t <= 11; t++)
      sb_q.push_back(op_exp(t, 1, 1) | op_exp(t - 3, 1, 1) | op_exp(t - 6, 1, 1) |
                     {3'b000, (t == 2 || t == 3 || t == 5 || t == 6 || t == 8 || t == 9)});
    for (int t = 0; t <= 11; t++) begin
      drive(1'b1, t <= 8, 1'b0, 1, 1);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL b2b t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  // Full-scale counters: y after edges 256..510, done after 511.
  task automatic test_max();
    for (int t = 0; t <= 513; t++) sb_q.push_back(op_exp(t, 255, 255));
    for (int t = 0; t <= 513; t++) begin
      drive(1'b1, t == 0, 1'b0, 255, 255);
      tick();
      exp_v = sb_q.pop_front();
      checks++;
      if ({y, busy, done, miss} !== exp_v) begin
        failures++;
        $display("FAIL max t=%0d got ybdm=%b exp=%b", t, {y, busy, done, miss}, exp_v);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    test_reset();
    test_basic();
    test_zero();
    test_drop();
    test_clr();
    test_rst_mid();
    test_back_to_back();
    test_max();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
